// File: rtl/seq_multiplier.sv
// seq_multiplier: responder side of the load/multiply handshake.
// Captures signed operands on load_data, acknowledges with loading_done,
// then runs a sign-magnitude shift-add multiply while mult_active is high.
// Reports completion with mult_done; product is held for the display path.
// Optional build macro: SEQ_MULT_EARLY_TERM_EN (stop iterating as soon as
// the remaining multiplier bits are all zero; product value is unchanged).
module seq_multiplier #(
   parameter int WIDTH = 8
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      clr,
   input  logic                      load_data,
   input  logic                      mult_active,
   input  logic signed [WIDTH-1:0]   multiplicand,
   input  logic signed [WIDTH-1:0]   multiplier,
   output logic                      loading_done,
   output logic                      mult_done,
   output logic signed [2*WIDTH-1:0] product,
   output logic                      busy
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LOADED = 3'd1,
      ARMED  = 3'd2,
      RUN    = 3'd3,
      FIX    = 3'd4,
      DONE   = 3'd5
   } state_t;

   state_t state, state_next;

   logic [2*WIDTH-1:0] mcand;
   logic [WIDTH-1:0]   mplier;
   logic [2*WIDTH-1:0] acc;
   logic [CW-1:0]      count;
   logic               sign;

   logic capture;
   logic step;
   logic finish;

   // Unsigned magnitude of a two's complement value; the most negative
   // value maps to 2^(WIDTH-1), which still fits in WIDTH unsigned bits.
   function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] v);
      logic [WIDTH-1:0] u;
      u = v;
      if (v[WIDTH-1]) u = -u;
      return u;
   endfunction

   // Re-apply the result sign to the unsigned accumulated magnitude.
   function automatic logic signed [2*WIDTH-1:0] apply_sign(input logic [2*WIDTH-1:0] mag,
                                                           input logic neg);
      logic [2*WIDTH-1:0] r;
      r = neg ? -mag : mag;
      return r;
   endfunction

   // State register; rst and clr both force IDLE.
   always_ff @(posedge clk) begin
      if (rst || clr) state <= IDLE;
      else            state <= state_next;
   end

   // Next-state decode plus datapath strobes and the busy flag.
   always_comb begin
      state_next = state;
      capture    = 1'b0;
      step       = 1'b0;
      finish     = 1'b0;
      busy       = 1'b0;
      unique case (state)
         IDLE, DONE: begin
            if (load_data) begin
               capture    = 1'b1;
               state_next = LOADED;
            end
         end
         LOADED: begin
            busy       = 1'b1;
            state_next = ARMED;
         end
         ARMED: begin
            busy = 1'b1;
            if (mult_active) begin
`ifdef SEQ_MULT_EARLY_TERM_EN
               state_next = (mplier == '0) ? FIX : RUN;
`else
               state_next = RUN;
`endif
            end else if (load_data) begin
               capture    = 1'b1;
               state_next = LOADED;
            end
         end
         RUN: begin
            busy = 1'b1;
            if (!mult_active) begin
               state_next = IDLE;
            end else begin
               step = 1'b1;
               if (count == CW'(WIDTH - 1)) state_next = FIX;
`ifdef SEQ_MULT_EARLY_TERM_EN
               else if (mplier[WIDTH-1:1] == '0) state_next = FIX;
`endif
            end
         end
         FIX: begin
            busy = 1'b1;
            if (!mult_active) begin
               state_next = IDLE;
            end else begin
               finish     = 1'b1;
               state_next = DONE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Operand capture, shift-add iteration, sign fix-up and handshake pulses.
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         mcand        <= '0;
         mplier       <= '0;
         acc          <= '0;
         count        <= '0;
         sign         <= 1'b0;
         product      <= '0;
         loading_done <= 1'b0;
         mult_done    <= 1'b0;
      end else begin
         loading_done <= capture;
         mult_done    <= finish;
         if (capture) begin
            mcand  <= {{WIDTH{1'b0}}, magnitude(multiplicand)};
            mplier <= magnitude(multiplier);
            sign   <= multiplicand[WIDTH-1] ^ multiplier[WIDTH-1];
            acc    <= '0;
            count  <= '0;
         end else if (step) begin
            if (mplier[0]) acc <= acc + mcand;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            count  <= count + CW'(1);
         end
         if (finish) product <= apply_sign(acc, sign);
      end
   end

endmodule

// File: tb/tb_seq_multiplier.sv
// Self-checking bench for seq_multiplier: directed handshake scenarios plus
// random operands, compared against plain integer multiplication.
module tb_seq_multiplier;

   localparam int WIDTH = 8;

   logic        clk = 1'b0;
   logic        rst;
   logic        clr;
   logic        load_data;
   logic        mult_active;
   logic [7:0]  multiplicand;
   logic [7:0]  multiplier;
   logic        loading_done;
   logic        mult_done;
   logic [15:0] product;
   logic        busy;

   int checks = 0;
   int errors = 0;
   logic [15:0] ref_prod;

   seq_multiplier #(.WIDTH(WIDTH)) dut (
      .clk          (clk),
      .rst          (rst),
      .clr          (clr),
      .load_data    (load_data),
      .mult_active  (mult_active),
      .multiplicand (multiplicand),
      .multiplier   (multiplier),
      .loading_done (loading_done),
      .mult_done    (mult_done),
      .product      (product),
      .busy         (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Cycles from the first mult_active cycle to the mult_done cycle.
   function automatic int expected_latency(input int b);
      int mag;
      mag = (b < 0) ? -b : b;
`ifdef SEQ_MULT_EARLY_TERM_EN
      return 2 + $clog2(mag + 1);
`else
      return WIDTH + 2;
`endif
   endfunction

   // Present operands with load_data, expect one loading_done pulse, end in ARMED.
   task automatic capture(input int a, input int b, input string tag);
      multiplicand = 8'(a);
      multiplier   = 8'(b);
      load_data    = 1'b1;
      step();
      check({tag, "/ld_pulse"}, 32'(loading_done), 32'd1);
      check({tag, "/ld_busy"}, 32'(busy), 32'd1);
      load_data    = 1'b0;
      multiplicand = 8'($urandom);
      multiplier   = 8'($urandom);
      step();
      check({tag, "/ld_clear"}, 32'(loading_done), 32'd0);
   endtask

   // From ARMED: raise mult_active, check held product, latency and result.
   task automatic run_armed(input int b, input logic [15:0] exp_p, input string tag);
      int lat;
      int seen;
      lat  = expected_latency(b);
      seen = -1;
      mult_active = 1'b1;
      for (int k = 1; k <= WIDTH + 6; k++) begin
         step();
         if (mult_done) begin
            seen = k;
            break;
         end
         check({tag, "/held"}, 32'(product), 32'(ref_prod));
      end
      check({tag, "/latency"}, 32'(seen), 32'(lat));
      check({tag, "/product"}, 32'(product), 32'(exp_p));
      check({tag, "/excl"}, 32'(loading_done), 32'd0);
      mult_active = 1'b0;
      ref_prod    = exp_p;
      step();
      check({tag, "/done_pulse"}, 32'(mult_done), 32'd0);
      check({tag, "/idle_busy"}, 32'(busy), 32'd0);
      check({tag, "/keep"}, 32'(product), 32'(exp_p));
   endtask

   task automatic run_mult(input int a, input int b, input string tag);
      capture(a, b, tag);
      run_armed(b, 16'(a * b), tag);
   endtask

   // Start a multiply, then hit the design with rst or clr during RUN.
   task automatic reset_in_run(input bit use_clr, input string tag);
      capture(9, -7, tag);
      mult_active = 1'b1;
      repeat (3) step();
      check({tag, "/run_busy"}, 32'(busy), 32'd1);
      if (use_clr) clr = 1'b1;
      else         rst = 1'b1;
      step();
      rst = 1'b0;
      clr = 1'b0;
      mult_active = 1'b0;
      check({tag, "/ld"}, 32'(loading_done), 32'd0);
      check({tag, "/md"}, 32'(mult_done), 32'd0);
      check({tag, "/prod"}, 32'(product), 32'd0);
      check({tag, "/busy"}, 32'(busy), 32'd0);
      ref_prod = 16'd0;
   endtask

   initial begin
      rst          = 1'b1;
      clr          = 1'b0;
      load_data    = 1'b0;
      mult_active  = 1'b0;
      multiplicand = 8'd0;
      multiplier   = 8'd0;
      ref_prod     = 16'd0;
      step();
      step();
      check("reset/ld", 32'(loading_done), 32'd0);
      check("reset/md", 32'(mult_done), 32'd0);
      check("reset/prod", 32'(product), 32'd0);
      check("reset/busy", 32'(busy), 32'd0);
      rst = 1'b0;
      step();

      run_mult(7, 6, "basic");
      check("basic/value", 32'(product), 32'h002A);
      run_mult(-5, 3, "mixed");
      check("mixed/value", 32'(product), 32'hFFF1);
      run_mult(3, -5, "swap");
      run_mult(-128, -128, "minmin");
      check("minmin/value", 32'(product), 32'h4000);
      run_mult(-128, 127, "minmax");
      check("minmax/value", 32'(product), 32'hC080);
      run_mult(85, 0, "zero_b");
      run_mult(0, -1, "zero_a");
      run_mult(-1, 1, "one");

      // Abort: drop mult_active mid-RUN; no mult_done, product kept.
      run_mult(7, 6, "pre_abort");
      capture(9, 9, "abort");
      mult_active = 1'b1;
      repeat (4) step();
      mult_active = 1'b0;
      step();
      check("abort/busy", 32'(busy), 32'd0);
      for (int k = 0; k < 4; k++) begin
         check("abort/md", 32'(mult_done), 32'd0);
         check("abort/prod", 32'(product), 32'h002A);
         step();
      end

      // Back-to-back from DONE: old product held until the new FIX.
      run_mult(7, 6, "b2b_first");
      run_mult(2, -3, "b2b_second");
      check("b2b/value", 32'(product), 32'hFFFA);

      // Re-capture while ARMED: the second operand pair wins.
      capture(4, 4, "recap_a");
      capture(-7, 11, "recap_b");
      run_armed(11, 16'(-77), "recap");

      // Random operands against integer multiplication.
      for (int i = 0; i < 12; i++) begin
         int a;
         int b;
         a = int'($urandom_range(0, 255)) - 128;
         b = int'($urandom_range(0, 255)) - 128;
         run_mult(a, b, "random");
      end

      run_mult(5, 5, "pre_rst");
      reset_in_run(1'b0, "rst_run");
      run_mult(-6, 7, "after_rst");
      reset_in_run(1'b1, "clr_run");
      run_mult(-1, -1, "after_clr");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/seq_multiplier.md
Name: seq_multiplier

Overview:
- Responder end of the control FSM's load/multiply handshake.
- Captures signed operands on `load_data`, acknowledges with `loading_done`, then runs a sign-magnitude shift-add multiply while `mult_active` is high.
- Reports completion with `mult_done` and holds `product` for the display path.
- Sits between the switch/operand inputs and the display scroller, alongside the control FSM.

Parameters:
- WIDTH, 8, operand width in bits (signed two's complement); product is 2*WIDTH bits.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- clr  input  1  synchronous clear, same effect as rst
- load_data  input  1  from control FSM; level, high while control is in LOAD
- mult_active  input  1  from control FSM; level, high while control is in MULT
- multiplicand  input  WIDTH  signed operand A
- multiplier  input  WIDTH  signed operand B
- loading_done  output  1  one-cycle pulse: operands captured
- mult_done  output  1  one-cycle pulse: product valid
- product  output  2*WIDTH  signed result, registered
- busy  output  1  high in LOADED, ARMED, RUN, FIX

Behaviour:
- One clock; reset is synchronous and active-high (`clk`, `rst`); `clr` behaves identically.
- Reset/clear state:
  - state=IDLE.
  - `loading_done`=0, `mult_done`=0, `product`=0, `busy`=0.
  - Internal accumulator, operand registers and counter all 0.
- States: IDLE, LOADED, ARMED, RUN, FIX, DONE.
- IDLE or DONE, `load_data`=1 at an edge:
  - Register `|A|` and `|B|` as WIDTH-bit unsigned values, and `sign`=A[MSB]^B[MSB].
  - Clear the accumulator and counter.
  - `loading_done`<=1; go to LOADED.
- LOADED:
  - `loading_done`<=0; go to ARMED unconditionally.
  - `load_data` is still high this cycle and is ignored.
- ARMED:
  - `mult_active`=1 -> RUN.
  - `load_data`=1 with `mult_active`=0 -> re-capture as in IDLE.
  - Otherwise stay.
- RUN, one iteration per edge:
  - If mplier[0]=1, acc += mcand (2*WIDTH-bit add, mcand zero-extended).
  - mcand <<= 1, mplier >>= 1, count++.
  - After WIDTH iterations -> FIX.
- FIX:
  - `product` <= sign ? -acc : acc (two's complement, 2*WIDTH bits).
  - `mult_done`<=1; go to DONE.
- DONE:
  - `mult_done`<=0 after one cycle.
  - `product` is held until the next capture; the capture itself does not clear `product`.
- Latency: c0 is the first cycle `mult_active` is high. `mult_done` is high in cycle c0+WIDTH+2 (c0+10 for WIDTH=8).
- `mult_active` falls while in RUN or FIX:
  - Abort to IDLE.
  - No `mult_done`; `product` keeps its previous value.
- `load_data` while in RUN or FIX: ignored.
- Operand inputs changing after capture: no effect.
- `rst`/`clr` in any state wins over every other condition on the same edge.
- Boundary values:
  - A=-2^(WIDTH-1): magnitude 2^(WIDTH-1) fits unsigned WIDTH bits.
  - (-128)*(-128)=+16384 is representable.
  - Either operand 0 gives `product`=0 regardless of sign.
- `mult_done` and `loading_done` are never high in the same cycle.

Optional Feature:
- Macro: SEQ_MULT_EARLY_TERM_EN.
- Defined:
  - In RUN, before each iteration, if the shifted mplier register is 0, go straight to FIX without iterating.
  - B=0 gives `mult_done` at c0+2; B=1 gives c0+3.
  - In general, c0+2+(index of highest set bit of |B|)+1.
- Undefined: fixed WIDTH iterations, fixed latency c0+WIDTH+2.
- `product` value is identical with and without the macro.

Test Plan:
- Basic multiply: A=7, B=6, `load_data` pulse, then `mult_active` held.
  - `loading_done` is a single pulse the cycle after capture.
  - `mult_done` at c0+10; `product`=0x002A.
- Mixed sign: A=-5 (0xFB), B=3.
  - `product`=0xFFF1.
  - Swap to A=3, B=-5: same result.
- Both minimum: A=-128, B=-128.
  - `product`=0x4000.
  - A=-128, B=127: `product`=0xC080.
- Zero operand: A=0x55, B=0.
  - `product`=0x0000.
  - `mult_done` at c0+10 with macro off; at c0+2 with SEQ_MULT_EARLY_TERM_EN on.
- Abort: start A=9, B=9, drop `mult_active` at c0+4.
  - No `mult_done`; `product` keeps its prior value (e.g. 0x002A).
  - State returns to IDLE; `busy`=0.
- Back-to-back and reset: from DONE, capture A=2, B=-3.
  - `product` stays 0x002A until FIX, then becomes 0xFFFA.
  - Assert `rst` during RUN: all outputs 0 the next cycle.
  - Repeat with `clr` instead of `rst`: same result.
